// File: rtl/spc_loader_pkg.sv
// Shared constants and state encoding for the UART RAM loader.
package spc_loader_pkg;

  localparam logic [7:0] CMD_PING  = 8'h50;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM, RD_FETCH, RD_SEND, TX_RESP, TX_WAIT
  } state_e;

  // Saturating increment used by the NAK counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/loader_tx_sequencer.sv
// Hands one byte at a time to uart_tx. A loaded byte is held until tx_ready,
// then strobed once. tx_ready is ignored in the strobe cycle itself because
// the transmitter cannot have reacted to the strobe yet.
module loader_tx_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_write,
  output logic       done
);

  logic       pend_q, pend_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_write_q, tx_write_d;

  // Latch a new byte, then fire it when the transmitter is idle.
  always_comb begin
    pend_d     = pend_q;
    hold_d     = hold_q;
    tx_byte_d  = tx_byte_q;
    tx_write_d = 1'b0;
    if (load) begin
      pend_d = 1'b1;
      hold_d = load_byte;
    end
    if (pend_d && tx_ready && !tx_write_q) begin
      tx_write_d = 1'b1;
      tx_byte_d  = hold_d;
      pend_d     = 1'b0;
    end
  end

  // Handshake registers; tx_byte only changes on a strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q     <= 1'b0;
      hold_q     <= '0;
      tx_byte_q  <= '0;
      tx_write_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      tx_byte_q  <= tx_byte_d;
      tx_write_q <= tx_write_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_write = tx_write_q;
  assign done     = tx_write_q;

endmodule

// File: rtl/spc_uart_loader.sv
// UART command decoder: ping, RAM write and RAM read packets, with per-byte
// inactivity timeout while a packet is open.
module spc_uart_loader
  import spc_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_write,
  input  logic        tx_ready,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_data_out,
  input  logic [7:0]  ram_data_in,
  output logic        ram_write_enable,
  output logic        dsp_hold,
  output logic [7:0]  error_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [8:0]    rem_q, rem_d;      // bytes still to move; 256 fits
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    resp_q, resp_d;
  logic          last_q, last_d;    // byte in flight ends the transaction
  logic          is_rd_q, is_rd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   ram_address_q, ram_address_d;
  logic [7:0]    ram_data_out_q, ram_data_out_d;
  logic          ram_we_q, ram_we_d;
  logic          dsp_hold_q, dsp_hold_d;
  logic [7:0]    err_q, err_d;
  logic          seq_load, seq_done;
  logic [7:0]    seq_byte;
  logic          rx_open;

  assign rx_open = state_q inside {ADDR_HI, ADDR_LO, LEN, DATA, CSUM};

  // Packet decode, RAM sequencing and response selection.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rem_d          = rem_q;
    csum_d         = csum_q;
    resp_d         = resp_q;
    last_d         = last_q;
    is_rd_d        = is_rd_q;
    tmo_d          = '0;
    ram_address_d  = ram_address_q;
    ram_data_out_d = ram_data_out_q;
    ram_we_d       = 1'b0;
    dsp_hold_d     = dsp_hold_q;
    err_d          = err_q;
    seq_load       = 1'b0;
    seq_byte       = resp_q;

    // Abandon an open packet after TIMEOUT_CYCLES silent cycles.
    if (rx_open && !rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        state_d    = IDLE;
        dsp_hold_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: if (rx_valid) begin
        case (rx_byte)
          CMD_PING: begin
            resp_d  = ACK;
            state_d = TX_RESP;
          end
          CMD_WRITE, CMD_READ: begin
            is_rd_d    = (rx_byte == CMD_READ);
            dsp_hold_d = 1'b1;
            state_d    = ADDR_HI;
          end
          default: begin
            resp_d  = NAK;
            err_d   = sat_inc(err_q);
            state_d = TX_RESP;
          end
        endcase
      end
      ADDR_HI: if (rx_valid) begin
        addr_d[15:8] = rx_byte;
        csum_d       = rx_byte;
        state_d      = ADDR_LO;
      end
      ADDR_LO: if (rx_valid) begin
        addr_d[7:0] = rx_byte;
        csum_d      = csum_q ^ rx_byte;
        state_d     = LEN;
      end
      LEN: if (rx_valid) begin
        rem_d = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
        if (is_rd_q) begin
          ram_address_d = addr_q;
          csum_d        = '0;
          state_d       = RD_FETCH;
        end else begin
          csum_d  = csum_q ^ rx_byte;
          state_d = DATA;
        end
      end
      DATA: if (rx_valid) begin
        ram_we_d       = 1'b1;
        ram_address_d  = addr_q;
        ram_data_out_d = rx_byte;
        addr_d         = addr_q + 16'd1;
        csum_d         = csum_q ^ rx_byte;
        rem_d          = rem_q - 9'd1;
        if (rem_q == 9'd1) state_d = CSUM;
      end
      CSUM: if (rx_valid) begin
        if (rx_byte == csum_q) begin
          resp_d = ACK;
        end else begin
          resp_d = NAK;
          err_d  = sat_inc(err_q);
        end
        state_d = TX_RESP;
      end
      // Address is on the port this cycle; data arrives next cycle.
      RD_FETCH: state_d = RD_SEND;
      RD_SEND: begin
        seq_load = 1'b1;
        seq_byte = ram_data_in;
        csum_d   = csum_q ^ ram_data_in;
        rem_d    = rem_q - 9'd1;
        last_d   = 1'b0;
        state_d  = TX_WAIT;
      end
      TX_RESP: begin
        seq_load = 1'b1;
        last_d   = 1'b1;
        state_d  = TX_WAIT;
      end
      TX_WAIT: if (seq_done) begin
        if (last_q) begin
          dsp_hold_d = 1'b0;
          state_d    = IDLE;
        end else if (rem_q == 9'd0) begin
          resp_d  = csum_q;
          state_d = TX_RESP;
        end else begin
          ram_address_d = ram_address_q + 16'd1;
          state_d       = RD_FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      rem_q          <= '0;
      csum_q         <= '0;
      resp_q         <= '0;
      last_q         <= 1'b0;
      is_rd_q        <= 1'b0;
      tmo_q          <= '0;
      ram_address_q  <= '0;
      ram_data_out_q <= '0;
      ram_we_q       <= 1'b0;
      dsp_hold_q     <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      rem_q          <= rem_d;
      csum_q         <= csum_d;
      resp_q         <= resp_d;
      last_q         <= last_d;
      is_rd_q        <= is_rd_d;
      tmo_q          <= tmo_d;
      ram_address_q  <= ram_address_d;
      ram_data_out_q <= ram_data_out_d;
      ram_we_q       <= ram_we_d;
      dsp_hold_q     <= dsp_hold_d;
      err_q          <= err_d;
    end
  end

  loader_tx_sequencer u_txseq (
    .clock     (clock),
    .reset     (reset),
    .load      (seq_load),
    .load_byte (seq_byte),
    .tx_ready  (tx_ready),
    .tx_byte   (tx_byte),
    .tx_write  (tx_write),
    .done      (seq_done)
  );

  assign ram_address      = ram_address_q;
  assign ram_data_out     = ram_data_out_q;
  assign ram_write_enable = ram_we_q;
  assign dsp_hold         = dsp_hold_q;
  assign error_count      = err_q;

endmodule

// File: tb/tb_spc_uart_loader.sv
// Bench for spc_uart_loader: table of packets, hand-written corner cases and
// random packets, all checked against a packet-level reference model.
module tb_spc_uart_loader;

  localparam int TMO = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_write;
  logic        tx_ready = 1'b1;
  logic [15:0] ram_address;
  logic [7:0]  ram_data_out;
  logic [7:0]  ram_data_in;
  logic        ram_write_enable;
  logic        dsp_hold;
  logic [7:0]  error_count;

  always #5 clock = ~clock;

  spc_uart_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_write(tx_write), .tx_ready(tx_ready),
    .ram_address(ram_address), .ram_data_out(ram_data_out),
    .ram_data_in(ram_data_in), .ram_write_enable(ram_write_enable),
    .dsp_hold(dsp_hold), .error_count(error_count)
  );

  int ncmp = 0;
  int nfail = 0;

  // RAM behind the DUT (unwritten cells read a fixed address pattern).
  logic [7:0]  mem    [logic [15:0]];
  logic [7:0]  shadow [logic [15:0]];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clock) begin
    ram_data_in <= mem.exists(ram_address) ? mem[ram_address] : dflt(ram_address);
    if (pre_en) mem[pre_addr] = pre_data;
    else if (ram_write_enable) mem[ram_address] = ram_data_out;
  end

  // Random or constant transmitter readiness.
  bit rdy_rand = 1'b0;
  initial forever begin
    @(posedge clock); #2;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Observers: every strobe and every RAM write, plus handshake sanity.
  logic [7:0]  txq [$];
  logic [23:0] wrq [$];
  int   hold_cnt = 0;
  int   bad_strobe = 0;
  logic last_hold = 1'b0;
  logic rdy_seen = 1'b1;
  always @(negedge clock) begin
    if (tx_write === 1'b1) begin
      txq.push_back(tx_byte);
      last_hold <= dsp_hold;
      if (rdy_seen !== 1'b1) bad_strobe <= bad_strobe + 1;
    end
    if (ram_write_enable === 1'b1) wrq.push_back({ram_address, ram_data_out});
    if (dsp_hold === 1'b1) hold_cnt <= hold_cnt + 1;
    rdy_seen <= tx_ready;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  // Packet-level reference model.
  logic [7:0]  pkt    [$];
  logic [7:0]  exp_tx [$];
  logic [23:0] exp_wr [$];
  int model_err = 0;

  function automatic logic [7:0] shrd(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction

  task automatic model();
    logic [15:0] a;
    logic [15:0] ad;
    logic [7:0]  x;
    logic [7:0]  d;
    int n;
    exp_tx.delete();
    exp_wr.delete();
    if (pkt[0] == 8'h50) begin
      exp_tx.push_back(8'h06);
    end else if (pkt[0] == 8'h57 || pkt[0] == 8'h52) begin
      a = {pkt[1], pkt[2]};
      n = (pkt[3] == 8'd0) ? 256 : int'(pkt[3]);
      if (pkt[0] == 8'h57) begin
        x = pkt[1] ^ pkt[2] ^ pkt[3];
        for (int i = 0; i < n; i++) begin
          ad = a + 16'(i);
          shadow[ad] = pkt[4 + i];
          exp_wr.push_back({ad, pkt[4 + i]});
          x ^= pkt[4 + i];
        end
        if (x == pkt[4 + n]) exp_tx.push_back(8'h06);
        else begin
          exp_tx.push_back(8'h15);
          if (model_err < 255) model_err++;
        end
      end else begin
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
          d = shrd(a + 16'(i));
          exp_tx.push_back(d);
          x ^= d;
        end
        exp_tx.push_back(x);
      end
    end else begin
      exp_tx.push_back(8'h15);
      if (model_err < 255) model_err++;
    end
  endtask

  // Send pkt, wait for the whole response, compare with the model.
  task automatic run_pkt(input string nm, input int gap);
    int tx0, wr0, k;
    model();
    tx0 = txq.size();
    wr0 = wrq.size();
    foreach (pkt[i]) send(pkt[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
    k = 0;
    while ((txq.size() - tx0) < exp_tx.size() && k < 5000) begin
      tick(1);
      k++;
    end
    if (k >= 5000) begin
      ncmp++;
      nfail++;
      $display("FAIL %s response wait: got %0d bytes, expected %0d", nm, txq.size() - tx0, exp_tx.size());
    end
    tick(4);
    chk({nm, " tx count"}, txq.size() - tx0, exp_tx.size());
    foreach (exp_tx[i])
      if (tx0 + i < txq.size()) chk($sformatf("%s tx[%0d]", nm, i), txq[tx0 + i], exp_tx[i]);
    chk({nm, " wr count"}, wrq.size() - wr0, exp_wr.size());
    foreach (exp_wr[i])
      if (wr0 + i < wrq.size()) chk($sformatf("%s wr[%0d]", nm, i), wrq[wr0 + i], exp_wr[i]);
    chk({nm, " error_count"}, error_count, model_err);
    chk({nm, " dsp_hold idle"}, dsp_hold, 1'b0);
  endtask

  task automatic build_random();
    logic [15:0] a;
    logic [7:0]  x, d, n;
    int k;
    pkt.delete();
    k = $urandom_range(0, 9);
    if (k < 2) pkt.push_back(8'h50);
    else if (k < 9) begin
      a = 16'($urandom);
      n = 8'($urandom_range(1, 6));
      pkt.push_back((k < 6) ? 8'h57 : 8'h52);
      pkt.push_back(a[15:8]);
      pkt.push_back(a[7:0]);
      pkt.push_back(n);
      if (k < 6) begin
        x = a[15:8] ^ a[7:0] ^ n;
        for (int i = 0; i < int'(n); i++) begin
          d = 8'($urandom);
          pkt.push_back(d);
          x ^= d;
        end
        if ($urandom_range(0, 3) == 0) x = ~x;
        pkt.push_back(x);
      end
    end else begin
      x = 8'($urandom);
      if (x == 8'h50 || x == 8'h57 || x == 8'h52) x = 8'hA5;
      pkt.push_back(x);
    end
  endtask

  typedef struct {
    int          n;
    logic [63:0] b;     // packet bytes, first byte in the top octet
    logic [7:0]  rsp;   // last byte transmitted
    int          err;   // error_count afterwards
    bit          hold;  // dsp_hold during the packet / at the final strobe
    int          nwr;   // RAM writes caused
  } vec_t;

  vec_t tbl [6];

  initial begin
    int t0, w0, hc0;

    // checksum of row 3: FF^FF^02^11^22 = 31
    tbl[0] = '{1, {8'h50, 56'h0},                                          8'h06, 0, 1'b0, 0};
    tbl[1] = '{8, {8'h57, 8'h02, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDC}, 8'h06, 0, 1'b1, 3};
    tbl[2] = '{8, {8'h57, 8'h02, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00}, 8'h15, 1, 1'b1, 3};
    tbl[3] = '{7, {8'h57, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h31, 8'h00}, 8'h06, 1, 1'b1, 2};
    tbl[4] = '{1, {8'hFF, 56'h0},                                          8'h15, 2, 1'b0, 0};
    tbl[5] = '{4, {8'h52, 8'h02, 8'h00, 8'h03, 32'h0},                      8'hDD, 2, 1'b1, 0};

    // Reset held three cycles.
    reset = 1'b1;
    @(posedge clock); #1;
    tick(2);
    chk("rst tx_byte", tx_byte, 8'h00);
    chk("rst tx_write", tx_write, 1'b0);
    chk("rst ram_address", ram_address, 16'h0000);
    chk("rst ram_data_out", ram_data_out, 8'h00);
    chk("rst ram_we", ram_write_enable, 1'b0);
    chk("rst dsp_hold", dsp_hold, 1'b0);
    chk("rst error_count", error_count, 8'h00);
    reset = 1'b0;
    tick(1);

    // Ping latency: strobe two cycles after the command byte.
    send(8'h50, 0);
    chk("ping c+1 tx_write", tx_write, 1'b0);
    tick(1);
    chk("ping c+2 tx_write", tx_write, 1'b1);
    chk("ping c+2 tx_byte", tx_byte, 8'h06);
    chk("ping dsp_hold", dsp_hold, 1'b0);
    tick(4);

    // Table-driven packets.
    for (int t = 0; t < 6; t++) begin
      pkt.delete();
      for (int j = 0; j < tbl[t].n; j++) pkt.push_back(tbl[t].b[63 - 8*j -: 8]);
      w0  = wrq.size();
      hc0 = hold_cnt;
      run_pkt($sformatf("vec%0d", t), 0);
      chk($sformatf("vec%0d last rsp", t), txq[txq.size() - 1], tbl[t].rsp);
      chk($sformatf("vec%0d err", t), error_count, tbl[t].err);
      chk($sformatf("vec%0d hold at strobe", t), last_hold, tbl[t].hold);
      chk($sformatf("vec%0d hold seen", t), hold_cnt > hc0, tbl[t].hold);
      chk($sformatf("vec%0d writes", t), wrq.size() - w0, tbl[t].nwr);
    end

    // Byte arriving while a response is pending is dropped.
    t0 = txq.size();
    send(8'h50, 0);
    send(8'h50, 0);
    tick(6);
    chk("drop during resp", txq.size() - t0, 1);

    // 256-byte read of preloaded index values with a jittery transmitter.
    for (int i = 0; i < 256; i++) begin
      pre_en   = 1'b1;
      pre_addr = 16'h0010 + 16'(i);
      pre_data = 8'(i);
      shadow[pre_addr] = pre_data;
      tick(1);
    end
    pre_en   = 1'b0;
    rdy_rand = 1'b1;
    pkt = '{8'h52, 8'h00, 8'h10, 8'h00};
    run_pkt("read256", -1);
    chk("read256 csum", txq[txq.size() - 1], 8'h00);

    // Random packets.
    for (int r = 0; r < 40; r++) begin
      build_random();
      run_pkt($sformatf("rand%0d", r), -1);
    end
    rdy_rand = 1'b0;

    // Longest accepted gap between bytes.
    pkt = '{8'h57, 8'h30, 8'h00, 8'h01, 8'h5A, 8'h6B};
    run_pkt("max gap", TMO - 1);

    // Timeout after a partial packet.
    t0 = txq.size();
    send(8'h57, 0);
    send(8'h12, 0);
    tick(TMO - 1);
    chk("tmo edge dsp_hold", dsp_hold, 1'b1);
    tick(2);
    chk("tmo dsp_hold", dsp_hold, 1'b0);
    chk("tmo no tx", txq.size() - t0, 0);
    chk("tmo error_count", error_count, model_err);
    pkt = '{8'h50};
    run_pkt("ping after tmo", 0);
    pkt = '{8'hFF};
    run_pkt("nak after tmo", 0);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) send(8'hFF, 3);
    tick(4);
    chk("err saturate", error_count, 8'hFF);
    model_err = 255;

    // Reset in the middle of a write packet.
    t0 = txq.size();
    w0 = wrq.size();
    send(8'h57, 0);
    send(8'h00, 0);
    send(8'h40, 0);
    send(8'h04, 0);
    send(8'h11, 0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("rst mid writes", wrq.size() - w0, 1);
    chk("rst mid write val", wrq[wrq.size() - 1], {16'h0040, 8'h11});
    chk("rst mid no tx", txq.size() - t0, 0);
    chk("rst mid error_count", error_count, 8'h00);
    chk("rst mid dsp_hold", dsp_hold, 1'b0);
    shadow[16'h0040] = 8'h11;
    model_err = 0;
    pkt = '{8'h52, 8'h00, 8'h40, 8'h01};
    run_pkt("read after rst", 0);

    chk("strobe without ready", bad_strobe, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
